fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch front end with a prefetch FIFO, replacing the fixed PC/PC+4 adder/IF_ID path of the 5-stage RISC-V pipeline. It owns the program counter, issues instruction-memory reads, buffers up to DEPTH fetched instructions with their PCs, and presents them to decode over a valid/ready handshake. A redirect input (taken branch, jump, exception) flushes the queue and restarts fetch at a new PC. This gives the pipeline stall and redirect capability.

## Interface

Parameters:
- XLEN, 32: PC width in bits.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  fetch enable; low stops new requests, while queued entries still drain.
- imem_req_o  out  1  fetch request this cycle.
- imem_addr_o  out  XLEN  fetch address, equal to the current PC.
- imem_data_i  in  32  instruction at imem_addr_o.
- imem_valid_i  in  1  imem_data_i is valid this cycle (supports wait states).
- redirect_i  in  1  flush and restart.
- redirect_pc_i  in  XLEN  restart PC; bits [1:0] are forced to 0.
- instr_valid_o  out  1  head entry is valid.
- instr_ready_i  in  1  decode accepts the head entry.
- instr_o  out  32  head instruction.
- pc_o  out  XLEN  PC of the head instruction.
- count_o  out  $clog2(DEPTH+1)  occupancy.

## Operation

- State: the PC register, DEPTH×(32+XLEN) storage, read and write pointers of log2(DEPTH) bits (natural wrap), and a count register.
- Request: imem_req_o = start_i & ~redirect_i & (count < DEPTH). This is a registered-state function only; it has no path from instr_ready_i.
- Push = imem_req_o & imem_valid_i. On push: write {imem_data_i, PC} at the write pointer, advance the write pointer, and set PC ← PC + 4, wrapping modulo 2^XLEN.
- Request with imem_valid_i low: PC holds and the request repeats next cycle (wait state).
- Pop = instr_valid_o & instr_ready_i & ~redirect_i. On pop, the read pointer advances.
- Count update: +1 on push only, −1 on pop only, unchanged when both or neither occur.
- Full (count = DEPTH): no request. A pop in the same cycle does not enable a push; the push resumes the next cycle.
- Empty: instr_valid_o = 0, and instr_o and pc_o are driven to 0.
- Redirect, which has highest priority: count ← 0, both pointers ← 0, and PC ← {redirect_pc_i[XLEN-1:2], 2'b00}. That cycle has no push and no pop, even if instr_ready_i is high. The instruction shown at the head that cycle is discarded.
- start_i low: no request and PC holds. Pops continue. A redirect is still honoured.

## Timing

- Reset (rst_i = 0, immediate, asynchronous):
  - PC = RESET_PC.
  - count = 0 and pointers = 0.
  - instr_valid_o = 0, imem_req_o = 0, instr_o = 0, pc_o = 0, count_o = 0.
- Reset asserted mid-operation discards all entries and any in-flight request immediately.
- After reset release, imem_req_o follows start_i combinationally; the first request is in the first cycle with start_i = 1.
- Fetch to decode latency: a push at edge N makes the entry visible on instr_valid_o/instr_o in cycle N+1. There is no same-cycle bypass.
- Throughput is one instruction per cycle when imem_valid_i = 1 and decode is always ready. Steady-state count is 1.
- Redirect at edge N: the first request to the new PC occurs in cycle N+1, and the first valid output in cycle N+2.
- instr_o and pc_o stay stable while instr_valid_o = 1 and instr_ready_i = 0.
- Outputs change only on a clock edge or on reset; they have no combinational path from instr_ready_i.

## Test plan

- Reset with RESET_PC = 0x100 and start_i = 1 held, decode always ready, memory returning addr>>2 → pc_o sequence 0x100, 0x104, 0x108, …, first valid output in cycle 2 after release, then valid every cycle.
- Backpressure: instr_ready_i = 0 for 10 cycles with DEPTH = 4 → count_o saturates at 4, imem_req_o = 0 when full. On release, entries 0x100–0x10C emerge in order, with no loss or duplication.
- Redirect to 0x2002 with 3 entries queued and instr_ready_i = 1 → that cycle produces no pop and count_o = 0. The next request is to 0x2000, and the next valid pc_o is 0x2000 two cycles later.
- Wait states: imem_valid_i pattern 1,0,0,1,0,1 → exactly three pushes, PCs consecutive with no gaps, and PC held during the low cycles.
- Wrap: RESET_PC = 0xFFFFFFF8, with 4+ pops to cycle the pointers → pc_o sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004. Pointers wrap correctly and count_o stays consistent.
- Asynchronous reset mid-stream, asserted between edges with 2 entries queued → instr_valid_o and count_o drop to 0 immediately, and the PC restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: instruction-memory request port, redirect input and the
// decode-side valid/ready head-of-queue port, bundled for the fetch queue.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            start_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic [31:0]     imem_data_i;
  logic            imem_valid_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            instr_valid_o;
  logic            instr_ready_i;
  logic [31:0]     instr_o;
  logic [XLEN-1:0] pc_o;
  logic [CW-1:0]   count_o;

  // Fetch unit side
  modport master (
    input  start_i, imem_data_i, imem_valid_i, redirect_i, redirect_pc_i, instr_ready_i,
    output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, count_o
  );

  // Environment side (memory, decode, redirect source)
  modport slave (
    output start_i, imem_data_i, imem_valid_i, redirect_i, redirect_pc_i, instr_ready_i,
    input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o, count_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues imem reads, buffers up to
// DEPTH fetched {instruction, PC} pairs and hands them to decode. A redirect
// flushes everything and restarts fetch at the (word-aligned) redirect PC.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] r_pc;
  logic [PW-1:0]   r_rd;
  logic [PW-1:0]   r_wr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_instr [DEPTH];
  logic [XLEN-1:0] r_pcq   [DEPTH];

  logic            w_full;
  logic            w_empty;
  logic            w_req;
  logic            w_push;
  logic            w_pop;
  logic [XLEN-1:0] w_redirect_pc;

  // Handshake decode; requests depend only on registered state, never on decode ready
  always_comb begin
    w_full        = (r_count == CW'(DEPTH));
    w_empty       = (r_count == {CW{1'b0}});
    w_req         = rst_i & bus.start_i & ~bus.redirect_i & ~w_full;
    w_push        = w_req & bus.imem_valid_i;
    w_pop         = ~w_empty & bus.instr_ready_i & ~bus.redirect_i;
    w_redirect_pc = bus.redirect_pc_i & ~XLEN'(3);
  end

  // PC, pointers and occupancy; redirect overrides any push or pop
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc    <= RESET_PC;
      r_rd    <= {PW{1'b0}};
      r_wr    <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else if (bus.redirect_i) begin
      r_pc    <= w_redirect_pc;
      r_rd    <= {PW{1'b0}};
      r_wr    <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_pc <= r_pc + XLEN'(4);
        r_wr <= r_wr + PW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only observable while counted as occupied
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_instr[r_wr] <= bus.imem_data_i;
      r_pcq[r_wr]   <= r_pc;
    end
  end

  // Output drive: head entry straight from storage, zeroed when empty
  always_comb begin
    bus.imem_req_o    = w_req;
    bus.imem_addr_o   = r_pc;
    bus.count_o       = r_count;
    bus.instr_valid_o = ~w_empty;
    if (w_empty) begin
      bus.instr_o = 32'h0000_0000;
      bus.pc_o    = {XLEN{1'b0}};
    end else begin
      bus.instr_o = r_instr[r_rd];
      bus.pc_o    = r_pcq[r_rd];
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based reference model predicts
// every output each cycle; directed phases pin the key scenarios with literals.
module tb_fetch_queue;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk_i (clk_i),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  // Instruction memory contents as a function of address
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a >> 2) ^ 32'h5A5A_0000;
  endfunction

  assign bus.imem_data_i = mem_f(bus.imem_addr_o);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of {instr, pc} and a PC
  logic [63:0] m_q[$];
  logic [31:0] m_pc = RPC;

  initial begin
    forever begin
      @(posedge clk_i or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_pc = RPC;
      end else begin
        bit req, push, pop;
        req  = bus.start_i && !bus.redirect_i && (m_q.size() < DEPTH);
        push = req && bus.imem_valid_i;
        pop  = (m_q.size() != 0) && bus.instr_ready_i && !bus.redirect_i;
        if (bus.redirect_i) begin
          m_q.delete();
          m_pc = bus.redirect_pc_i & 32'hFFFF_FFFC;
        end else begin
          if (pop) void'(m_q.pop_front());
          if (push) begin
            m_q.push_back({mem_f(m_pc), m_pc});
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  // Compare process: every output against the model, mid-cycle
  always @(negedge clk_i) begin
    logic        e_req;
    logic [31:0] e_instr, e_pc;
    e_req   = rst_n && bus.start_i && !bus.redirect_i && (m_q.size() < DEPTH);
    e_instr = (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
    e_pc    = (m_q.size() != 0) ? m_q[0][31:0]  : 32'h0;
    chk("imem_req",    {63'd0, bus.imem_req_o},    {63'd0, e_req});
    chk("imem_addr",   {32'd0, bus.imem_addr_o},   {32'd0, m_pc});
    chk("instr_valid", {63'd0, bus.instr_valid_o}, {63'd0, (m_q.size() != 0)});
    chk("instr",       {32'd0, bus.instr_o},       {32'd0, e_instr});
    chk("pc",          {32'd0, bus.pc_o},          {32'd0, e_pc});
    chk("count",       {61'd0, bus.count_o},       64'(m_q.size()));
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  int pat[6] = '{1, 0, 0, 1, 0, 1};

  initial begin
    bus.start_i       = 1'b1;
    bus.instr_ready_i = 1'b1;
    bus.imem_valid_i  = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    repeat (3) step();
    chk("rst_count", {61'd0, bus.count_o}, 64'd0);
    chk("rst_valid", {63'd0, bus.instr_valid_o}, 64'd0);
    chk("rst_req",   {63'd0, bus.imem_req_o}, 64'd0);
    chk("rst_pc_o",  {32'd0, bus.pc_o}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("first_req",  {63'd0, bus.imem_req_o}, 64'd1);
    chk("first_addr", {32'd0, bus.imem_addr_o}, 64'h100);
    step();
    chk("first_valid", {63'd0, bus.instr_valid_o}, 64'd1);
    chk("first_pc",    {32'd0, bus.pc_o}, 64'h100);
    chk("first_instr", {32'd0, bus.instr_o}, 64'h5A5A_0040);
    step();
    chk("second_pc",    {32'd0, bus.pc_o}, 64'h104);
    chk("steady_count", {61'd0, bus.count_o}, 64'd1);
    repeat (4) step();

    // Backpressure: refill from 0x100 with decode stalled
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h100; bus.instr_ready_i = 1'b0;
    step();
    bus.redirect_i = 1'b0;
    repeat (10) step();
    chk("bp_count", {61'd0, bus.count_o}, 64'd4);
    chk("bp_req",   {63'd0, bus.imem_req_o}, 64'd0);
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_drain_pc", {32'd0, bus.pc_o}, 64'(32'h100 + 32'(4 * i)));
      step();
    end

    // Redirect to 0x2002 with three entries queued
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h500; bus.instr_ready_i = 1'b0;
    step();
    bus.redirect_i = 1'b0;
    repeat (3) step();
    bus.start_i = 1'b0;
    step();
    chk("rd_pre_count", {61'd0, bus.count_o}, 64'd3);
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h2002; bus.instr_ready_i = 1'b1; bus.start_i = 1'b1;
    #1;
    chk("rd_cycle_req", {63'd0, bus.imem_req_o}, 64'd0);
    step();
    bus.redirect_i = 1'b0;
    #1;
    chk("rd_count", {61'd0, bus.count_o}, 64'd0);
    chk("rd_addr",  {32'd0, bus.imem_addr_o}, 64'h2000);
    chk("rd_req",   {63'd0, bus.imem_req_o}, 64'd1);
    step();
    chk("rd_valid", {63'd0, bus.instr_valid_o}, 64'd1);
    chk("rd_pc",    {32'd0, bus.pc_o}, 64'h2000);

    // Wait states: valid pattern 1,0,0,1,0,1
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h3000; bus.instr_ready_i = 1'b0;
    step();
    bus.redirect_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.imem_valid_i = (pat[i] != 0);
      step();
    end
    bus.imem_valid_i = 1'b0;
    #1;
    chk("ws_count", {61'd0, bus.count_o}, 64'd3);
    chk("ws_addr",  {32'd0, bus.imem_addr_o}, 64'h300C);
    chk("ws_head",  {32'd0, bus.pc_o}, 64'h3000);
    bus.imem_valid_i = 1'b1;

    // Wrap past the top of the address space
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFF8; bus.instr_ready_i = 1'b1;
    step();
    bus.redirect_i = 1'b0;
    step();
    chk("wrap_pc0", {32'd0, bus.pc_o}, 64'hFFFF_FFF8);
    step();
    chk("wrap_pc1", {32'd0, bus.pc_o}, 64'hFFFF_FFFC);
    step();
    chk("wrap_pc2", {32'd0, bus.pc_o}, 64'h0000_0000);
    step();
    chk("wrap_pc3", {32'd0, bus.pc_o}, 64'h0000_0004);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.start_i       = ($urandom_range(7, 0) != 0);
      bus.instr_ready_i = ($urandom_range(2, 0) != 0);
      bus.imem_valid_i  = ($urandom_range(3, 0) != 0);
      bus.redirect_i    = ($urandom_range(15, 0) == 0);
      bus.redirect_pc_i = $urandom;
      step();
    end

    // Asynchronous reset mid-stream with two entries queued
    bus.start_i = 1'b1; bus.imem_valid_i = 1'b1; bus.instr_ready_i = 1'b0;
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h700;
    step();
    bus.redirect_i = 1'b0;
    step();
    step();
    chk("ar_pre_count", {61'd0, bus.count_o}, 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {63'd0, bus.instr_valid_o}, 64'd0);
    chk("ar_count", {61'd0, bus.count_o}, 64'd0);
    chk("ar_req",   {63'd0, bus.imem_req_o}, 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("ar_addr", {32'd0, bus.imem_addr_o}, 64'h100);
    bus.instr_ready_i = 1'b1;
    step();
    chk("ar_pc", {32'd0, bus.pc_o}, 64'h100);
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
